// File: rtl/multi_digit_display.sv
// Multiplexed seven-segment driver: serial binary-to-BCD/hex conversion feeding a scanned display.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits above digit 0.
module multi_digit_display #(
  parameter int DATA_WIDTH  = 16,
  parameter int DIGITS      = 5,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] value,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic                  busy,
  output logic                  overflow,
  output logic [7:0]            sseg_indicator,
  output logic [DIGITS-1:0]     digits
);

  localparam int WORK_W = 4 * (DIGITS + 1);
  localparam int CNT_W  = $clog2(DATA_WIDTH);
  localparam int REF_W  = $clog2(REFRESH_DIV);
  localparam int SCAN_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CONVERT = 2'd1, COMMIT = 2'd2} state_e;

  state_e state_q, state_d;
  logic   start, shift_en, commit_en;

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [WORK_W-1:0]     work_q, work_d, work_corr;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  hex_q, hex_d;
  logic                  lost_q, lost_d;
  logic [4*DIGITS-1:0]   disp_q, disp_d;
  logic                  ovf_q, ovf_d;

  logic [REF_W-1:0]      refresh_q, refresh_d;
  logic [SCAN_W-1:0]     scan_q, scan_d;
  logic [DIGITS-1:0]     digits_q, digits_d;
  logic [7:0]            sseg_q, sseg_d;
  logic [DIGITS-1:0]     blank;

  function automatic logic [WORK_W-1:0] add3(input logic [WORK_W-1:0] w);
    add3 = w;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (w[i*4 +: 4] >= 4'd5) add3[i*4 +: 4] = w[i*4 +: 4] + 4'd3;
    end
  endfunction

  function automatic logic [7:0] seg_lut(input logic [3:0] nib);
    case (nib)
      4'h0: seg_lut = 8'hC0;
      4'h1: seg_lut = 8'hF9;
      4'h2: seg_lut = 8'hA4;
      4'h3: seg_lut = 8'hB0;
      4'h4: seg_lut = 8'h99;
      4'h5: seg_lut = 8'h92;
      4'h6: seg_lut = 8'h82;
      4'h7: seg_lut = 8'hF8;
      4'h8: seg_lut = 8'h80;
      4'h9: seg_lut = 8'h90;
      4'hA: seg_lut = 8'h88;
      4'hB: seg_lut = 8'h83;
      4'hC: seg_lut = 8'hC6;
      4'hD: seg_lut = 8'hA1;
      4'hE: seg_lut = 8'h86;
      default: seg_lut = 8'h8E;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = CONVERT;
      CONVERT: if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    start     = (state_q == IDLE) && load;
    shift_en  = (state_q == CONVERT);
    commit_en = (state_q == COMMIT);
  end

  // Double-dabble: correct then shift in the next MSB; bits pushed out of the top are remembered.
  always_comb begin
    work_corr = hex_q ? work_q : add3(work_q);
    shift_d   = shift_q;
    work_d    = work_q;
    hex_d     = hex_q;
    lost_d    = lost_q;
    bit_cnt_d = bit_cnt_q;
    disp_d    = disp_q;
    ovf_d     = ovf_q;
    if (start) begin
      shift_d   = value;
      work_d    = '0;
      hex_d     = hex_mode;
      lost_d    = 1'b0;
      bit_cnt_d = '0;
    end else if (shift_en) begin
      shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
      work_d    = {work_corr[WORK_W-2:0], shift_q[DATA_WIDTH-1]};
      lost_d    = lost_q | work_corr[WORK_W-1];
      bit_cnt_d = bit_cnt_q + 1'b1;
    end else if (commit_en) begin
      disp_d = work_q[4*DIGITS-1:0];
      ovf_d  = lost_q | (|work_q[WORK_W-1 -: 4]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q   <= '0;
      work_q    <= '0;
      hex_q     <= 1'b0;
      lost_q    <= 1'b0;
      bit_cnt_q <= '0;
      disp_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      work_q    <= work_d;
      hex_q     <= hex_d;
      lost_q    <= lost_d;
      bit_cnt_q <= bit_cnt_d;
      disp_q    <= disp_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    refresh_d = refresh_q + 1'b1;
    scan_d    = scan_q;
    if (refresh_q == REF_W'(REFRESH_DIV - 1)) begin
      refresh_d = '0;
      scan_d    = (scan_q == SCAN_W'(DIGITS - 1)) ? '0 : scan_q + 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_run;
  always_comb begin
    zero_run = 1'b1;
    blank    = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run & (disp_q[i*4 +: 4] == 4'd0);
      blank[i] = zero_run;
    end
  end
`else
  assign blank = '0;
`endif

  logic [3:0] sel_nib;
  logic       sel_blank, sel_dp;
  logic [7:0] seg_raw;

  always_comb begin
    sel_nib   = '0;
    sel_blank = 1'b0;
    sel_dp    = 1'b0;
    digits_d  = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_q == SCAN_W'(i)) begin
        sel_nib     = disp_q[i*4 +: 4];
        sel_blank   = blank[i];
        sel_dp      = dp_mask[i];
        digits_d[i] = 1'b0;
      end
    end
    if (ovf_q)          seg_raw = 8'hBF;
    else if (sel_blank) seg_raw = 8'hFF;
    else                seg_raw = seg_lut(sel_nib);
    sseg_d = {seg_raw[7] & ~sel_dp, seg_raw[6:0]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_q <= '0;
      scan_q    <= '0;
      digits_q  <= '1;
      sseg_q    <= 8'hFF;
    end else begin
      refresh_q <= refresh_d;
      scan_q    <= scan_d;
      digits_q  <= digits_d;
      sseg_q    <= sseg_d;
    end
  end

  assign overflow       = ovf_q;
  assign sseg_indicator = sseg_q;
  assign digits         = digits_q;

endmodule

// File: tb/tb_multi_digit_display.sv
// Self-checking bench: a 5-digit and a 3-digit instance checked against an arithmetic display model.
module tb_multi_digit_display;

  localparam int DW    = 16;
  localparam int RDIV5 = 4;
  localparam int RDIV3 = 3;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  localparam logic [7:0] SEG_TABLE [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] value5, value3;
  logic          load5, load3, hex5, hex3;
  logic [4:0]    dp5;
  logic [2:0]    dp3;
  logic          busy5, busy3, ovf5, ovf3;
  logic [7:0]    sseg5, sseg3;
  logic [4:0]    dig5;
  logic [2:0]    dig3;

  int n_assert = 0;
  int n_fail   = 0;
  bit exp_ovf [2];

  always #5 clk = ~clk;

  multi_digit_display #(.DATA_WIDTH(DW), .DIGITS(5), .REFRESH_DIV(RDIV5)) u_dut5 (
    .clk(clk), .reset(reset), .value(value5), .load(load5), .hex_mode(hex5), .dp_mask(dp5),
    .busy(busy5), .overflow(ovf5), .sseg_indicator(sseg5), .digits(dig5));

  multi_digit_display #(.DATA_WIDTH(DW), .DIGITS(3), .REFRESH_DIV(RDIV3)) u_dut3 (
    .clk(clk), .reset(reset), .value(value3), .load(load3), .hex_mode(hex3), .dp_mask(dp3),
    .busy(busy3), .overflow(ovf3), .sseg_indicator(sseg3), .digits(dig3));

  function automatic longint ipow(input longint base, input int e);
    longint p = 1;
    for (int k = 0; k < e; k++) p = p * base;
    return p;
  endfunction

  function automatic bit model_ovf(input bit sel, input longint v, input bit hx);
    return v >= ipow(hx ? 16 : 10, sel ? 3 : 5);
  endfunction

  function automatic logic [7:0] model_seg(input bit sel, input longint v, input bit hx,
                                           input int idx, input bit dp);
    longint base, pi;
    int dg;
    logic [7:0] r;
    base = hx ? 16 : 10;
    pi   = ipow(base, idx);
    dg   = int'((v / pi) % base);
    if (model_ovf(sel, v, hx))          r = 8'hBF;
    else if (LZB && idx > 0 && v < pi)  r = 8'hFF;
    else                                r = SEG_TABLE[dg];
    if (dp) r[7] = 1'b0;
    return r;
  endfunction

  task automatic drive(input bit sel, input logic [DW-1:0] v, input bit hx, input bit ld);
    if (sel) begin value3 = v; hex3 = hx; load3 = ld; end
    else     begin value5 = v; hex5 = hx; load5 = ld; end
  endtask

  task automatic sample(input bit sel, output logic [7:0] d, output logic [7:0] s,
                        output logic b, output logic o);
    if (sel) begin d = {5'h1F, dig3}; s = sseg3; b = busy3; o = ovf3; end
    else     begin d = {3'h7, dig5};  s = sseg5; b = busy5; o = ovf5; end
  endtask

  // Load v and track busy length and the exact cycle the overflow flag takes its new value.
  task automatic run_load(input bit sel, input logic [DW-1:0] v, input bit hx,
                          input int inj_k, input logic [DW-1:0] v2, input string tag);
    logic [7:0] d, s;
    logic b, o, ovf_before, ovf_after;
    int high_cnt, first_low;
    bit new_ovf;
    high_cnt = 0; first_low = 0; ovf_before = 1'b0; ovf_after = 1'b0;
    new_ovf = model_ovf(sel, v, hx);
    @(negedge clk); drive(sel, v, hx, 1'b1);
    @(posedge clk);
    for (int k = 1; k <= DW + 3; k++) begin
      @(negedge clk);
      sample(sel, d, s, b, o);
      if (k == 1) drive(sel, v, hx, 1'b0);
      if (inj_k > 0 && k == inj_k)     drive(sel, v2, ~hx, 1'b1);
      if (inj_k > 0 && k == inj_k + 1) drive(sel, v, hx, 1'b0);
      if (b) high_cnt++;
      else if (first_low == 0) first_low = k;
      if (k == DW + 1) ovf_before = o;
      if (k == DW + 2) ovf_after = o;
    end
    n_assert++;
    if (high_cnt !== DW + 1) begin
      n_fail++; $display("FAIL %s busy_len: got %0d expected %0d", tag, high_cnt, DW + 1);
    end
    n_assert++;
    if (first_low !== DW + 2) begin
      n_fail++; $display("FAIL %s busy_fall: got cycle %0d expected %0d", tag, first_low, DW + 2);
    end
    n_assert++;
    if (ovf_before !== exp_ovf[sel]) begin
      n_fail++; $display("FAIL %s ovf_early: got %b expected %b", tag, ovf_before, exp_ovf[sel]);
    end
    n_assert++;
    if (ovf_after !== new_ovf) begin
      n_fail++; $display("FAIL %s ovf_commit: got %b expected %b", tag, ovf_after, new_ovf);
    end
    exp_ovf[sel] = new_ovf;
  endtask

  // Watch a full scan cycle and compare every slot against the model.
  task automatic check_display(input bit sel, input logic [DW-1:0] v, input bit hx,
                               input logic [4:0] dpm, input string tag);
    logic [7:0] d, s, e;
    logic b, o;
    int nd, rd, idx, zeros;
    nd = sel ? 3 : 5;
    rd = sel ? RDIV3 : RDIV5;
    @(negedge clk);
    if (sel) dp3 = dpm[2:0]; else dp5 = dpm;
    repeat (3) @(negedge clk);
    for (int k = 0; k < nd * rd + 2; k++) begin
      @(negedge clk);
      sample(sel, d, s, b, o);
      zeros = 0; idx = 0;
      for (int i = 0; i < nd; i++) if (d[i] === 1'b0) begin zeros++; idx = i; end
      n_assert++;
      if (zeros != 1) begin
        n_fail++; $display("FAIL %s digits_onehot: got %b", tag, d);
      end else begin
        e = model_seg(sel, v, hx, idx, dpm[idx]);
        n_assert++;
        if (s !== e) begin
          n_fail++; $display("FAIL %s sseg digit%0d: got %h expected %h", tag, idx, s, e);
        end
      end
    end
    n_assert++;
    if (o !== exp_ovf[sel]) begin
      n_fail++; $display("FAIL %s overflow: got %b expected %b", tag, o, exp_ovf[sel]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_assert++;
    if ({busy5, ovf5, dig5, sseg5} !== {1'b0, 1'b0, 5'h1F, 8'hFF}) begin
      n_fail++; $display("FAIL %s dut5: got b=%b o=%b d=%b s=%h expected b=0 o=0 d=11111 s=ff",
                         tag, busy5, ovf5, dig5, sseg5);
    end
    n_assert++;
    if ({busy3, ovf3, dig3, sseg3} !== {1'b0, 1'b0, 3'h7, 8'hFF}) begin
      n_fail++; $display("FAIL %s dut3: got b=%b o=%b d=%b s=%h expected b=0 o=0 d=111 s=ff",
                         tag, busy3, ovf3, dig3, sseg3);
    end
  endtask

  task automatic test_reset();
    logic [4:0] e5;
    logic [2:0] e3;
    int i5, i3;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    exp_ovf[0] = 1'b0; exp_ovf[1] = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      i5 = ((k - 1) / RDIV5) % 5;
      i3 = ((k - 1) / RDIV3) % 3;
      e5 = '1; e5[i5] = 1'b0;
      e3 = '1; e3[i3] = 1'b0;
      n_assert++;
      if (dig5 !== e5 || sseg5 !== model_seg(1'b0, 0, 1'b0, i5, 1'b0)) begin
        n_fail++; $display("FAIL scan5 k=%0d: got d=%b s=%h expected d=%b s=%h",
                           k, dig5, sseg5, e5, model_seg(1'b0, 0, 1'b0, i5, 1'b0));
      end
      n_assert++;
      if (dig3 !== e3) begin
        n_fail++; $display("FAIL scan3 k=%0d: got d=%b expected d=%b", k, dig3, e3);
      end
    end
  endtask

  task automatic test_decimal();
    run_load(1'b0, 16'd12345, 1'b0, 0, '0, "dec12345");
    check_display(1'b0, 16'd12345, 1'b0, 5'b00000, "dec12345");
    check_display(1'b0, 16'd12345, 1'b0, 5'b10010, "dec12345_dp");
  endtask

  task automatic test_hex();
    run_load(1'b0, 16'hBEEF, 1'b1, 0, '0, "hexBEEF");
    check_display(1'b0, 16'hBEEF, 1'b1, 5'b00000, "hexBEEF");
  endtask

  task automatic test_overflow();
    run_load(1'b1, 16'd1000, 1'b0, 0, '0, "ovf1000");
    check_display(1'b1, 16'd1000, 1'b0, 3'b000, "ovf1000");
    run_load(1'b1, 16'd999, 1'b0, 0, '0, "dec999");
    check_display(1'b1, 16'd999, 1'b0, 3'b000, "dec999");
    run_load(1'b1, 16'h1234, 1'b1, 0, '0, "hexovf");
    check_display(1'b1, 16'h1234, 1'b1, 3'b010, "hexovf");
  endtask

  task automatic test_back_to_back();
    run_load(1'b0, 16'd321, 1'b0, 3, 16'd4660, "ignore");
    check_display(1'b0, 16'd321, 1'b0, 5'b00001, "ignore");
  endtask

  task automatic test_reset_mid();
    @(negedge clk); drive(1'b0, 16'd4321, 1'b0, 1'b1);
    @(negedge clk); drive(1'b0, 16'd4321, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    @(negedge clk); reset = 1'b1;
    exp_ovf[0] = 1'b0; exp_ovf[1] = 1'b0;
    repeat (2) @(negedge clk);
    n_assert++;
    if (busy5 !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid busy_after: got %b expected 0", busy5);
    end
    check_display(1'b0, 16'd0, 1'b0, 5'b00100, "reset_mid_zero");
    run_load(1'b0, 16'd4321, 1'b0, 0, '0, "after_reset");
    check_display(1'b0, 16'd4321, 1'b0, 5'b00000, "after_reset");
  endtask

  task automatic test_random();
    logic [DW-1:0] v;
    bit hx;
    logic [4:0] dpm;
    for (int n = 0; n < 6; n++) begin
      v = DW'($urandom_range(0, 65535));
      if (n % 3 == 0) v = DW'($urandom_range(0, 150));
      hx = 1'($urandom);
      dpm = 5'($urandom);
      run_load(1'b0, v, hx, 0, '0, "rand5");
      check_display(1'b0, v, hx, dpm, "rand5");
    end
    for (int n = 0; n < 6; n++) begin
      v = (n % 2 == 0) ? DW'($urandom_range(0, 1200)) : DW'($urandom_range(0, 65535));
      hx = 1'($urandom);
      dpm = 5'($urandom);
      run_load(1'b1, v, hx, 0, '0, "rand3");
      check_display(1'b1, v, hx, dpm, "rand3");
    end
  endtask

  initial begin
    reset = 1'b0;
    value5 = '0; value3 = '0; load5 = 1'b0; load3 = 1'b0;
    hex5 = 1'b0; hex3 = 1'b0; dp5 = '0; dp3 = '0;
    test_reset();
    test_decimal();
    test_hex();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_digit_display.md
MULTI_DIGIT_DISPLAY -- requirements
Module: multi_digit_display

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of the binary input value (range 4..32).
REQ-002 Parameter DIGITS, default 5, number of seven-segment digits driven (range 1..8).
REQ-003 Parameter REFRESH_DIV, default 100000, clk cycles per digit scan slot (minimum 2).
REQ-004 clk  input  1  single system clock; all logic on posedge clk.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 value  input  DATA_WIDTH  binary number to display.
REQ-007 load  input  1  one-cycle strobe; captures value and hex_mode.
REQ-008 hex_mode  input  1  1 = hexadecimal digits, 0 = decimal (BCD).
REQ-009 dp_mask  input  DIGITS  per-digit decimal point enable, 1 = lit, sampled live.
REQ-010 busy  output  1  high while a conversion is in progress.
REQ-011 overflow  output  1  high when the last committed value did not fit in DIGITS digits.
REQ-012 sseg_indicator  output  8  active-low segments, bit7 = dp, bits6..0 = g..a.
REQ-013 digits  output  DIGITS  active-low one-hot digit enable; bit 0 = least significant digit.

Function
REQ-014 FSM states: IDLE, CONVERT, COMMIT; reset state IDLE.
REQ-015 IDLE: load=1 captures value/hex_mode into shift register, clears working digits, goes to CONVERT; busy rises next cycle.
REQ-016 CONVERT: exactly DATA_WIDTH cycles, MSB first; decimal mode applies add-3 to every working nibble >=5 before each shift; hex mode shifts without correction.
REQ-017 COMMIT: one cycle; copies working digits to display register, updates overflow, returns to IDLE with busy=0.
REQ-018 Latency: display register and overflow update exactly DATA_WIDTH+2 cycles after the load cycle; busy high for DATA_WIDTH+1 cycles.
REQ-019 load while busy=1 is ignored; no queuing; the in-flight conversion completes unchanged.
REQ-020 Working register holds DIGITS+1 nibbles; overflow = any nonzero bit above nibble DIGITS-1 at COMMIT (decimal 99999 fits at defaults, hex >0xFFFFF not possible at defaults).
REQ-021 When overflow=1, every digit shows segment g only (8'b10111111, dp per dp_mask).
REQ-022 Refresh counter counts 0..REFRESH_DIV-1 then wraps; on wrap scan index increments, wrapping DIGITS-1 -> 0.
REQ-023 digits = ~(1 << scan index); sseg_indicator = registered decode of display nibble at scan index, updated same edge as digits.
REQ-024 Decode: 0..9 = C0,F9,A4,B0,99,92,82,F8,80,90; A..F = 88,83,C6,A1,86,8E (hex, bit7=1); bit7 forced 0 when dp_mask[scan index]=1.
REQ-025 Display register is only written in COMMIT; scanning continues uninterrupted during conversion, showing the previous value.

Reset
REQ-026 reset low asynchronously forces: state IDLE, busy 0, overflow 0, counters 0, scan index 0, display register 0, digits all ones, sseg_indicator 8'hFF.
REQ-027 reset asserted mid-CONVERT aborts the conversion; display keeps no partial result; first scan slot after release selects digit 0 with value 0.

Configuration
REQ-028 Macro LEADING_ZERO_BLANK_EN defined: any digit index >0 whose nibble and all higher nibbles are zero outputs 8'hFF (bit7 still follows dp_mask); digit 0 always shown.
REQ-029 Macro LEADING_ZERO_BLANK_EN undefined: all DIGITS digits shown, zeros included.

Verification
REQ-030 Reset then release, REFRESH_DIV=4 -> digits 11110, sseg C0 (or FF on digits>0 with blanking); digit advances every 4 cycles, wraps after 5 slots.
REQ-031 load value=12345 decimal -> busy high 17 cycles, display nibbles 5,4,3,2,1 at cycle 18; digit 0 shows 92, digit 4 shows F9.
REQ-032 load value=16'hBEEF hex_mode=1 -> digits show F,E,E,b,0 (8E,86,86,83, C0 or FF per macro); overflow 0.
REQ-033 DIGITS=3, load 1000 decimal -> overflow 1, all digits BF; then load 999 -> overflow 0, 90 on all digits.
REQ-034 Second load 3 cycles into conversion -> ignored, first value committed; reset pulse mid-CONVERT -> busy 0, display 0, next load converts normally.
